vga_draw_arbiter: RTL and testbench

Shares the single VGA adapter pixel-write port between several drawing clients, for example note display, octave meter and status text. After reset, and on request, it first clears the 160x120 frame to black. It then grants the port to one client at a time for a burst, in round-robin order, with a burst-length watchdog. It sits between the `vga_data`-style drawing engines and the VGA adapter, and is the only block that drives the adapter's `x`, `y`, `colour` and `writeEn`.

---
 rtl/vga_draw_arbiter.sv | 143 ++++++++++++++
 tb/tb_vga_draw_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_draw_arbiter.sv
// Arbiter for the single VGA adapter pixel-write port: clears the 160x120 frame
// to black, then grants round-robin bursts to drawing clients with a burst watchdog.
module vga_draw_arbiter #(
    parameter int NUM_CLIENTS = 3,
    parameter int MAX_BURST   = 512
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_req,
    input  logic [NUM_CLIENTS-1:0]   req,
    input  logic [NUM_CLIENTS-1:0]   done,
    input  logic [8*NUM_CLIENTS-1:0] x_in,
    input  logic [7*NUM_CLIENTS-1:0] y_in,
    input  logic [3*NUM_CLIENTS-1:0] colour_in,
    input  logic [NUM_CLIENTS-1:0]   we_in,
    output logic [NUM_CLIENTS-1:0]   grant,
    output logic [7:0]               x_out,
    output logic [6:0]               y_out,
    output logic [2:0]               colour,
    output logic                     writeEn,
    output logic                     clearing
);

    localparam int IW = $clog2(NUM_CLIENTS);
    localparam int BW = 10;

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_GRANT, S_RELEASE} state_t;

    state_t        state;
    logic [7:0]    xc;
    logic [6:0]    yc;
    logic [IW-1:0] ptr;
    logic [IW-1:0] gidx;
    logic [BW-1:0] burst;
    logic          clr_pend;

    logic [7:0]    cx  [NUM_CLIENTS];
    logic [6:0]    cy  [NUM_CLIENTS];
    logic [2:0]    cc  [NUM_CLIENTS];
    logic [IW-1:0] pick_idx;
    logic          pick_valid;
    logic [IW:0]   slot;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            cx[i] = x_in[8*i +: 8];
            cy[i] = y_in[7*i +: 7];
            cc[i] = colour_in[3*i +: 3];
        end
    end

    // Circular search starting at ptr; the extra slot bit absorbs the wrap.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        slot       = '0;
        for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
            slot = {1'b0, ptr} + (IW+1)'(k);
            if (slot >= (IW+1)'(NUM_CLIENTS))
                slot = slot - (IW+1)'(NUM_CLIENTS);
            if (!pick_valid && req[slot[IW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = slot[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_CLEAR;
            xc       <= '0;
            yc       <= '0;
            ptr      <= '0;
            gidx     <= '0;
            burst    <= '0;
            clr_pend <= 1'b0;
            grant    <= '0;
            x_out    <= '0;
            y_out    <= '0;
            colour   <= '0;
            writeEn  <= 1'b0;
            clearing <= 1'b1;
        end else begin
            case (state)
                S_CLEAR: begin
                    x_out   <= xc;
                    y_out   <= yc;
                    colour  <= '0;
                    writeEn <= 1'b1;
                    grant   <= '0;
                    if (xc == 8'd159) begin
                        xc <= '0;
                        if (yc == 7'd119) begin
                            yc       <= '0;
                            clearing <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            yc <= yc + 7'd1;
                        end
                    end else begin
                        xc <= xc + 8'd1;
                    end
                end
                S_IDLE: begin
                    writeEn <= 1'b0;
                    if (clear_req || clr_pend) begin
                        clr_pend <= 1'b0;
                        clearing <= 1'b1;
                        state    <= S_CLEAR;
                    end else if (pick_valid) begin
                        gidx  <= pick_idx;
                        grant <= {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << pick_idx;
                        burst <= '0;
                        state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    x_out   <= cx[gidx];
                    y_out   <= cy[gidx];
                    colour  <= cc[gidx];
                    writeEn <= we_in[gidx];
                    burst   <= burst + 1'b1;
                    if (clear_req)
                        clr_pend <= 1'b1;
                    if (done[gidx] || burst == BW'(MAX_BURST-1)) begin
                        grant <= '0;
                        state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    writeEn <= 1'b0;
                    grant   <= '0;
                    ptr     <= (gidx == IW'(NUM_CLIENTS-1)) ? '0 : gidx + 1'b1;
                    if (clear_req)
                        clr_pend <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Self-checking bench for vga_draw_arbiter: directed scenarios plus randomized
// bursts checked against a transaction-level round-robin model.
module tb_vga_draw_arbiter;

    localparam int N  = 3;
    localparam int MB = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         clear_req = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] done = '0;
    logic [8*N-1:0] x_in = '0;
    logic [7*N-1:0] y_in = '0;
    logic [3*N-1:0] colour_in = '0;
    logic [N-1:0] we_in = '0;
    logic [N-1:0] grant;
    logic [7:0]   x_out;
    logic [6:0]   y_out;
    logic [2:0]   colour;
    logic         writeEn;
    logic         clearing;

    int n_cmp = 0;
    int n_err = 0;
    int ptr_m = 0;

    logic [7:0] px [N];
    logic [6:0] py [N];
    logic [2:0] pc [N];
    logic       pw [N];

    vga_draw_arbiter #(.NUM_CLIENTS(N), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset), .clear_req(clear_req), .req(req), .done(done),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .we_in(we_in),
        .grant(grant), .x_out(x_out), .y_out(y_out), .colour(colour),
        .writeEn(writeEn), .clearing(clearing)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (p + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic rand_pixels();
        for (int i = 0; i < N; i++) begin
            px[i] = 8'($urandom_range(0, 159));
            py[i] = 7'($urandom_range(0, 119));
            pc[i] = 3'($urandom);
            pw[i] = 1'($urandom);
            x_in[8*i +: 8]      = px[i];
            y_in[7*i +: 7]      = py[i];
            colour_in[3*i +: 3] = pc[i];
            we_in[i]            = pw[i];
        end
    endtask

    // Observes one full clear; pulse_at>0 injects a clear_req after that many writes.
    task automatic run_clear(input int pulse_at, output int writes,
                             output logic [7:0] fx, output logic [6:0] fy,
                             output logic [7:0] lx, output logic [6:0] ly,
                             output int bad_col, output int grant_seen,
                             output logic clr_first, output logic clr_end,
                             output logic timed_out);
        writes = 0; bad_col = 0; grant_seen = 0; timed_out = 1'b1;
        fx = '0; fy = '0; lx = '0; ly = '0; clr_first = 1'b0; clr_end = 1'b1;
        for (int t = 0; t < 20500; t++) begin
            clear_req = (pulse_at > 0 && writes == pulse_at);
            step();
            if (writeEn) begin
                if (writes == 0) begin
                    fx = x_out; fy = y_out; clr_first = clearing;
                end
                lx = x_out; ly = y_out;
                if (colour != 3'd0) bad_col++;
                if (grant != '0) grant_seen++;
                writes++;
            end else if (writes > 0) begin
                clr_end = clearing;
                timed_out = 1'b0;
                break;
            end
        end
        clear_req = 1'b0;
    endtask

    task automatic test_reset();
        int w, bc, gs;
        logic [7:0] fx, lx;
        logic [6:0] fy, ly;
        logic cf, ce, to;
        #1 reset = 1'b0;
        #2;
        n_cmp++;
        if ({grant, x_out, y_out, colour, writeEn, clearing} !== {3'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want %h", {grant, x_out, y_out, colour, writeEn, clearing}, 1'b1);
        end
        step(); step();
        n_cmp++;
        if (writeEn !== 1'b0) begin
            n_err++; $display("FAIL reset_held_we: got %b want 0", writeEn);
        end
        #2 reset = 1'b1;
        run_clear(-1, w, fx, fy, lx, ly, bc, gs, cf, ce, to);
        n_cmp++;
        if (to !== 1'b0) begin n_err++; $display("FAIL clear_timeout: got timeout want completion"); end
        n_cmp++;
        if (w !== 19200) begin n_err++; $display("FAIL clear_count: got %0d want 19200", w); end
        n_cmp++;
        if ({fx, fy} !== {8'd0, 7'd0}) begin n_err++; $display("FAIL clear_first: got (%0d,%0d) want (0,0)", fx, fy); end
        n_cmp++;
        if ({lx, ly} !== {8'd159, 7'd119}) begin n_err++; $display("FAIL clear_last: got (%0d,%0d) want (159,119)", lx, ly); end
        n_cmp++;
        if (bc !== 0) begin n_err++; $display("FAIL clear_colour: got %0d nonblack want 0", bc); end
        n_cmp++;
        if (gs !== 0) begin n_err++; $display("FAIL clear_grant: got %0d granted cycles want 0", gs); end
        n_cmp++;
        if ({cf, ce} !== 2'b10) begin n_err++; $display("FAIL clear_flag: got first=%b end=%b want 1 0", cf, ce); end
        ptr_m = 0;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_seq [4];
        exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100; exp_seq[3] = 3'b001;
        req = 3'b111;
        for (int b = 0; b < 4; b++) begin
            int g;
            logic [N-1:0] oh;
            g = pick(req, ptr_m);
            oh = 3'(1 << g);
            step();
            n_cmp++;
            if (grant !== exp_seq[b] || grant !== oh) begin
                n_err++; $display("FAIL rr_grant%0d: got %b want %b", b, grant, exp_seq[b]);
            end
            for (int k = 0; k < 4; k++) begin
                rand_pixels();
                done = (k == 3) ? oh : 3'b000;
                step();
                n_cmp++;
                if ({x_out, y_out, colour, writeEn} !== {px[g], py[g], pc[g], pw[g]}) begin
                    n_err++; $display("FAIL rr_pixel: got %h want %h", {x_out, y_out, colour, writeEn}, {px[g], py[g], pc[g], pw[g]});
                end
                n_cmp++;
                if (grant !== ((k == 3) ? 3'b000 : oh)) begin
                    n_err++; $display("FAIL rr_hold: got %b want %b", grant, (k == 3) ? 3'b000 : oh);
                end
            end
            done = '0;
            ptr_m = (g + 1) % N;
            step();
            n_cmp++;
            if ({grant, writeEn} !== 4'b0000) begin
                n_err++; $display("FAIL rr_turnaround: got %b want 0000", {grant, writeEn});
            end
        end
        req = '0;
    endtask

    task automatic test_forwarding();
        req = 3'b010;
        step();
        n_cmp++;
        if (grant !== 3'b010) begin n_err++; $display("FAIL fwd_grant: got %b want 010", grant); end
        rand_pixels();
        x_in[15:8] = 8'd10; y_in[13:7] = 7'd20; colour_in[5:3] = 3'b101; we_in[1] = 1'b1;
        step();
        n_cmp++;
        if ({x_out, y_out, colour, writeEn} !== {8'd10, 7'd20, 3'b101, 1'b1}) begin
            n_err++; $display("FAIL fwd_pixel: got (%0d,%0d,%b,%b) want (10,20,101,1)", x_out, y_out, colour, writeEn);
        end
        x_in[15:8] = 8'd11; we_in[1] = 1'b0; done = 3'b010;
        step();
        n_cmp++;
        if ({x_out, writeEn, grant} !== {8'd11, 1'b0, 3'b000}) begin
            n_err++; $display("FAIL fwd_done_pixel: got %h want %h", {x_out, writeEn, grant}, {8'd11, 1'b0, 3'b000});
        end
        done = '0; ptr_m = 2;
        step();
        req = '0;
    endtask

    task automatic test_watchdog();
        int g;
        req = 3'b001;
        g = pick(req, ptr_m);
        step();
        n_cmp++;
        if (grant !== 3'(1 << g) || g != 0) begin n_err++; $display("FAIL wd_grant: got %b want 001", grant); end
        req = 3'b010;
        for (int k = 0; k < 9; k++) begin
            rand_pixels();
            x_in[7:0] = 8'(k + 1); we_in[0] = 1'b1;
            done = (k % 2 == 1) ? 3'b110 : 3'b000;
            step();
            if (k < MB) begin
                n_cmp++;
                if ({x_out, writeEn} !== {8'(k + 1), 1'b1}) begin
                    n_err++; $display("FAIL wd_pixel%0d: got %0d/%b want %0d/1", k + 1, x_out, writeEn, k + 1);
                end
                n_cmp++;
                if (grant !== ((k < MB - 1) ? 3'b001 : 3'b000)) begin
                    n_err++; $display("FAIL wd_hold%0d: got %b want %b", k, grant, (k < MB - 1) ? 3'b001 : 3'b000);
                end
            end else begin
                n_cmp++;
                if (writeEn !== 1'b0) begin n_err++; $display("FAIL wd_drop: got we=%b want 0", writeEn); end
            end
        end
        done = '0;
        ptr_m = 1;
        g = pick(req, ptr_m);
        step();
        n_cmp++;
        if (grant !== 3'(1 << g)) begin n_err++; $display("FAIL wd_next: got %b want %b", grant, 3'(1 << g)); end
        rand_pixels();
        done = 3'b010;
        step();
        done = '0; ptr_m = 2;
        step();
        req = '0;
    endtask

    task automatic test_clear_during_grant();
        int w, bc, gs;
        logic [7:0] fx, lx;
        logic [6:0] fy, ly;
        logic cf, ce, to;
        req = 3'b100;
        step();
        n_cmp++;
        if (grant !== 3'b100) begin n_err++; $display("FAIL cdg_grant: got %b want 100", grant); end
        req = 3'b101;
        for (int k = 0; k < 5; k++) begin
            rand_pixels();
            clear_req = (k == 1);
            done = (k == 4) ? 3'b100 : 3'b000;
            step();
            n_cmp++;
            if ({x_out, y_out, colour, writeEn, grant} !== {px[2], py[2], pc[2], pw[2], (k == 4) ? 3'b000 : 3'b100}) begin
                n_err++; $display("FAIL cdg_burst%0d: got %h want %h", k, {x_out, y_out, colour, writeEn, grant},
                                  {px[2], py[2], pc[2], pw[2], (k == 4) ? 3'b000 : 3'b100});
            end
        end
        clear_req = 1'b0; done = '0; ptr_m = 0;
        step();
        run_clear(-1, w, fx, fy, lx, ly, bc, gs, cf, ce, to);
        n_cmp++;
        if (to !== 1'b0 || w !== 19200) begin n_err++; $display("FAIL cdg_clear_count: got %0d want 19200", w); end
        n_cmp++;
        if ({fx, fy, lx, ly, gs} !== {8'd0, 7'd0, 8'd159, 7'd119, 32'd0}) begin
            n_err++; $display("FAIL cdg_clear_span: got (%0d,%0d)..(%0d,%0d) g=%0d want (0,0)..(159,119) g=0", fx, fy, lx, ly, gs);
        end
        n_cmp++;
        if (grant !== 3'(1 << pick(3'b101, ptr_m))) begin
            n_err++; $display("FAIL cdg_after: got %b want 001", grant);
        end
        rand_pixels();
        done = 3'b001;
        step();
        done = '0; ptr_m = 1;
        step();
        req = '0;
    endtask

    task automatic test_reset_mid_clear();
        int w, bc, gs;
        logic [7:0] fx, lx;
        logic [6:0] fy, ly;
        logic cf, ce, to;
        logic found;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        n_cmp++;
        if (clearing !== 1'b1) begin n_err++; $display("FAIL idle_clear_req: got %b want 1", clearing); end
        found = 1'b0;
        for (int t = 0; t < 20000; t++) begin
            step();
            if (writeEn && x_out == 8'd50 && y_out == 7'd60) begin found = 1'b1; break; end
        end
        n_cmp++;
        if (found !== 1'b1) begin n_err++; $display("FAIL mid_clear_reach: got none want pixel (50,60)"); end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({grant, x_out, y_out, colour, writeEn, clearing} !== {3'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL mid_reset_outputs: got %h want %h", {grant, x_out, y_out, colour, writeEn, clearing}, 1'b1);
        end
        step(); step();
        #2 reset = 1'b1;
        run_clear(5000, w, fx, fy, lx, ly, bc, gs, cf, ce, to);
        n_cmp++;
        if (to !== 1'b0 || w !== 19200) begin n_err++; $display("FAIL restart_count: got %0d want 19200", w); end
        n_cmp++;
        if ({fx, fy, lx, ly} !== {8'd0, 7'd0, 8'd159, 7'd119}) begin
            n_err++; $display("FAIL restart_span: got (%0d,%0d)..(%0d,%0d) want (0,0)..(159,119)", fx, fy, lx, ly);
        end
        ptr_m = 0;
        req = 3'b111;
        step();
        n_cmp++;
        if (grant !== 3'b001) begin n_err++; $display("FAIL ptr_reset: got %b want 001", grant); end
        rand_pixels();
        done = 3'b001;
        step();
        done = '0; ptr_m = 1;
        step();
        req = '0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 80; it++) begin
            logic [N-1:0] r, oh;
            int g, len, end_k;
            r = 3'($urandom);
            if ($urandom_range(0, 4) == 0) r = '0;
            req = r;
            g = pick(r, ptr_m);
            if (g < 0) begin
                rand_pixels();
                step();
                n_cmp++;
                if ({grant, writeEn} !== 4'b0000) begin n_err++; $display("FAIL rnd_idle: got %b want 0000", {grant, writeEn}); end
                continue;
            end
            oh = 3'(1 << g);
            step();
            n_cmp++;
            if (grant !== oh) begin n_err++; $display("FAIL rnd_grant: got %b want %b", grant, oh); end
            len = $urandom_range(1, 11);
            end_k = (len - 1 < MB - 1) ? len - 1 : MB - 1;
            for (int k = 0; k <= end_k; k++) begin
                rand_pixels();
                req = 3'($urandom);
                done = 3'($urandom) & ~oh;
                if (k == len - 1) done = done | oh;
                step();
                n_cmp++;
                if ({x_out, y_out, colour, writeEn} !== {px[g], py[g], pc[g], pw[g]}) begin
                    n_err++; $display("FAIL rnd_pixel: got %h want %h", {x_out, y_out, colour, writeEn}, {px[g], py[g], pc[g], pw[g]});
                end
                n_cmp++;
                if (grant !== ((k == end_k) ? 3'b000 : oh)) begin
                    n_err++; $display("FAIL rnd_hold: got %b want %b", grant, (k == end_k) ? 3'b000 : oh);
                end
            end
            done = '0; req = '0;
            ptr_m = (g + 1) % N;
            step();
            n_cmp++;
            if ({grant, writeEn} !== 4'b0000) begin n_err++; $display("FAIL rnd_release: got %b want 0000", {grant, writeEn}); end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_forwarding();
        test_watchdog();
        test_clear_during_grant();
        test_reset_mid_clear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
